fmul_pipe: RTL and testbench

FMUL_PIPE -- requirements
Module: fmul_pipe

---
 rtl/fmul_pipe.sv | 154 +++++++++++++++
 tb/tb_fmul_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage pipelined floating-point multiplier with valid/ready handshake,
// flush-to-zero inputs, truncate or round-to-nearest-even, and a caller tag carried per operation.
module fmul_pipe #(
    parameter int EW = 8,
    parameter int MW = 23,
    parameter int TW = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [EW+MW:0] x1,
    input  logic [EW+MW:0] x2,
    input  logic           rm,
    input  logic [TW-1:0]  in_tag,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [EW+MW:0] y,
    output logic [TW-1:0]  out_tag,
    output logic           ovf,
    output logic           unf,
    output logic           nv,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam logic [EW+1:0]  BIAS = {3'b000, {(EW-1){1'b1}}};
    localparam logic [EW:0]    EMAX = {1'b0, {EW{1'b1}}};
    localparam logic [1:0]     K_NUM = 2'd0, K_NAN = 2'd1, K_INF = 2'd2, K_ZERO = 2'd3;
    localparam logic [EW+MW:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic            rdy_q, v1_q, v2_q, v3_q, adv2, adv3;
    logic            s1_sign_q, s1_nv_q, s1_rm_q, s2_sign_q, s2_nv_q, s2_rm_q;
    logic [EW+1:0]   s1_e_q, s2_e_q;
    logic [MW:0]     s1_ma_q, s1_mb_q;
    logic [1:0]      s1_kind_q, s2_kind_q;
    logic [TW-1:0]   s1_tag_q, s2_tag_q, tag_q;
    logic [2*MW+1:0] s2_p_q;
    logic [EW+MW:0]  y_q;
    logic            ovf_q, unf_q, nv_q;

    // operand classification for S1
    logic [EW-1:0] e1, e2;
    logic [MW-1:0] m1, m2;
    logic          z1, z2, i1, i2, n1, n2, bad;
    logic [1:0]    kind_d;
    logic [EW+1:0] esum_d;

    assign e1 = x1[EW+MW-1:MW];
    assign e2 = x2[EW+MW-1:MW];
    assign m1 = x1[MW-1:0];
    assign m2 = x2[MW-1:0];
    assign z1 = ~|e1;
    assign z2 = ~|e2;
    assign i1 = &e1 && ~|m1;
    assign i2 = &e2 && ~|m2;
    assign n1 = &e1 && |m1;
    assign n2 = &e2 && |m2;
    assign bad = (i1 && z2) || (i2 && z1);
    assign kind_d = (n1 || n2 || bad) ? K_NAN : (i1 || i2) ? K_INF : (z1 || z2) ? K_ZERO : K_NUM;
    assign esum_d = {2'b00, e1} + {2'b00, e2} - BIAS;

    // normalize by at most one bit, then round and pack in S3
    logic            norm, grd, stk, inc, ovf_n, unf_n;
    logic [2*MW:0]   sh;
    logic [MW-1:0]   mant;
    logic [MW:0]     mr;
    logic [EW+1:0]   ef;
    logic [EW+MW:0]  y_num, y_d;

    assign norm  = s2_p_q[2*MW+1];
    assign sh    = norm ? s2_p_q[2*MW:0] : {s2_p_q[2*MW-1:0], 1'b0};
    assign mant  = sh[2*MW:MW+1];
    assign grd   = sh[MW];
    assign stk   = |sh[MW-1:0];
    assign inc   = s2_rm_q && grd && (stk || mant[0]);
    assign mr    = {1'b0, mant} + {{MW{1'b0}}, inc};
    assign ef    = s2_e_q + {{(EW+1){1'b0}}, norm} + {{(EW+1){1'b0}}, mr[MW]};
    assign ovf_n = !ef[EW+1] && ef[EW:0] >= EMAX;
    assign unf_n = ef[EW+1] || ef == '0;
    assign y_num = ovf_n ? {s2_sign_q, {EW{1'b1}}, {MW{1'b0}}} :
                   unf_n ? {s2_sign_q, {(EW+MW){1'b0}}} : {s2_sign_q, ef[EW-1:0], mr[MW-1:0]};
    assign y_d   = (s2_kind_q == K_NAN)  ? QNAN :
                   (s2_kind_q == K_INF)  ? {s2_sign_q, {EW{1'b1}}, {MW{1'b0}}} :
                   (s2_kind_q == K_ZERO) ? {s2_sign_q, {(EW+MW){1'b0}}} : y_num;

    assign adv3     = !v3_q || out_ready;
    assign adv2     = !v2_q || adv3;
    assign in_ready = rdy_q && (!v1_q || adv2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q     <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_nv_q   <= 1'b0;
            s1_rm_q   <= 1'b0;
            s1_e_q    <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s1_kind_q <= K_NUM;
            s1_tag_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_nv_q   <= 1'b0;
            s2_rm_q   <= 1'b0;
            s2_e_q    <= '0;
            s2_p_q    <= '0;
            s2_kind_q <= K_NUM;
            s2_tag_q  <= '0;
            y_q       <= '0;
            tag_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            nv_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (in_ready) begin
                v1_q      <= in_valid;
                s1_sign_q <= x1[EW+MW] ^ x2[EW+MW];
                s1_nv_q   <= bad && !(n1 || n2);
                s1_rm_q   <= rm;
                s1_e_q    <= esum_d;
                s1_ma_q   <= {1'b1, m1};
                s1_mb_q   <= {1'b1, m2};
                s1_kind_q <= kind_d;
                s1_tag_q  <= in_tag;
            end
            if (adv2) begin
                v2_q      <= v1_q;
                s2_sign_q <= s1_sign_q;
                s2_nv_q   <= s1_nv_q;
                s2_rm_q   <= s1_rm_q;
                s2_e_q    <= s1_e_q;
                s2_p_q    <= s1_ma_q * s1_mb_q;
                s2_kind_q <= s1_kind_q;
                s2_tag_q  <= s1_tag_q;
            end
            if (adv3) begin
                v3_q  <= v2_q;
                y_q   <= y_d;
                tag_q <= s2_tag_q;
                ovf_q <= v2_q && s2_kind_q == K_NUM && ovf_n;
                unf_q <= v2_q && s2_kind_q == K_NUM && !ovf_n && unf_n;
                nv_q  <= v2_q && s2_kind_q == K_NAN && s2_nv_q;
            end
        end
    end

    assign y         = y_q;
    assign out_tag   = tag_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign nv        = nv_q;
    assign out_valid = v3_q;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed vectors into a scoreboard queue, checked by an independent output monitor.
module tb_fmul_pipe;
    logic        clk = 1'b0, rstn = 1'b0, rm = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] x1 = '0, x2 = '0, y;
    logic [3:0]  in_tag = '0, out_tag;
    logic        in_ready, ovf, unf, nv, out_valid;
    int          checks = 0, errors = 0, cyc = 0;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic [2:0]  f;
        bit          lat;
        bit          burst;
        int          acc;
    } exp_t;
    exp_t sb[$];

    fmul_pipe #(.EW(8), .MW(23), .TW(4)) dut (
        .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .rm(rm), .in_tag(in_tag),
        .in_valid(in_valid), .in_ready(in_ready), .y(y), .out_tag(out_tag),
        .ovf(ovf), .unf(unf), .nv(nv), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    // entered and left just after a rising edge; expectation pushed when acceptance is certain
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic r, input logic [3:0] t,
                        input logic [31:0] ey, input logic [2:0] ef, input bit lat, input bit burst);
        int n = 0;
        bit ok = 0;
        x1 = a; x2 = b; rm = r; in_tag = t; in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{ey, t, ef, lat, burst, cyc});
                ok = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   last = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!out_valid) chk("idle_flags", 32'({ovf, unf, nv}), 32'd0);
            else if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output y=%h tag=%0d", y, out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("y", y, e.y);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("flags", 32'({ovf, unf, nv}), 32'(e.f));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
                    if (e.burst) chk("gap", 32'(cyc - last), 32'd1);
                end
                last = cyc;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", 32'({ovf, unf, nv}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("in_ready_after_edge", 32'(in_ready), 32'd1);

        send(32'h40000000, 32'h40400000, 1, 4'd5, 32'h40C00000, 3'b000, 1, 0);
        drain();

        send(32'h3FC00001, 32'h3FC00001, 1, 4'd1, 32'h40100002, 3'b000, 0, 0);
        send(32'h3FC00001, 32'h3FC00001, 0, 4'd2, 32'h40100001, 3'b000, 0, 0);
        send(32'h7F000000, 32'h40000000, 1, 4'd3, 32'h7F800000, 3'b100, 0, 0);
        send(32'h00800000, 32'h3F000000, 1, 4'd4, 32'h00000000, 3'b010, 0, 0);
        send(32'h7F800000, 32'h80000000, 1, 4'd6, 32'h7FC00000, 3'b001, 0, 0);
        send(32'h7FC00000, 32'h3F800000, 1, 4'd7, 32'h7FC00000, 3'b000, 0, 0);
        send(32'hFF800000, 32'h40000000, 1, 4'd8, 32'hFF800000, 3'b000, 0, 0);
        send(32'h80000000, 32'h40400000, 1, 4'd9, 32'h80000000, 3'b000, 0, 0);
        send(32'h3FFFFFFE, 32'h3F800001, 1, 4'd10, 32'h40000000, 3'b000, 0, 0);
        send(32'h3FFFFFFE, 32'h3F800001, 0, 4'd11, 32'h3FFFFFFF, 3'b000, 0, 0);
        drain();

        out_ready = 1'b0;
        send(32'h40000000, 32'h40400000, 1, 4'd10, 32'h40C00000, 3'b000, 0, 0);
        send(32'h3FC00001, 32'h3FC00001, 1, 4'd11, 32'h40100002, 3'b000, 0, 1);
        send(32'h7F000000, 32'h40000000, 1, 4'd12, 32'h7F800000, 3'b100, 0, 1);
        fork
            begin
                send(32'h7F800000, 32'h00000000, 1, 4'd13, 32'h7FC00000, 3'b001, 0, 1);
                send(32'h3FFFFFFE, 32'h3F800001, 1, 4'd14, 32'h40000000, 3'b000, 0, 1);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_y", y, 32'h40C00000);
                    chk("stall_tag", 32'(out_tag), 32'd10);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(32'h40000000, 32'h40400000, 1, 4'd1, 32'h40C00000, 3'b000, 0, 0);
        send(32'h40000000, 32'h40400000, 1, 4'd2, 32'h40C00000, 3'b000, 0, 0);
        send(32'h40000000, 32'h40400000, 1, 4'd3, 32'h40C00000, 3'b000, 0, 0);
        chk("inflight_valid", 32'(out_valid), 32'd1);
        #1 rstn = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", y, 32'd0);
        chk("midrst_tag", 32'(out_tag), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(32'h80000000, 32'h40400000, 1, 4'd9, 32'h80000000, 3'b000, 1, 0);
        drain();
        repeat (5) @(posedge clk);
        #1 chk("final_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
